// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_serial_adder_pkg;
  localparam int BCD_W    = 4;
  localparam int BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_bad(input logic [BCD_W-1:0] d);
    return d > BCD_W'(9);
  endfunction
endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal adder with carry; purely combinational.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [BCD_W-1:0] a_d,
  input  logic [BCD_W-1:0] b_d,
  input  logic             c,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);
  logic [BCD_W:0] w_t;
  logic [BCD_W:0] w_adj;

  assign w_t   = {1'b0, a_d} + {1'b0, b_d} + {{BCD_W{1'b0}}, c};
  assign w_adj = w_t + (BCD_W+1)'(BCD_CORR);

  always_comb begin
    carry = w_t > (BCD_W+1)'(9);
    digit = carry ? w_adj[BCD_W-1:0] : w_t[BCD_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit per clock through a shared digit adder.
// Optional err port and invalid-digit check enabled by BCD_SERIAL_CHECK_EN.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   s,
  output logic                  cout
`ifdef BCD_SERIAL_CHECK_EN
  ,
  output logic                  err
`endif
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t r_state, w_next;

  logic [DIGITS-1:0][BCD_W-1:0] r_a, r_b, r_s;
  logic [IW-1:0]                r_idx;
  logic                         r_carry;
  logic                         r_cout;
  logic                         w_accept;
  logic                         w_last;
  logic [BCD_W-1:0]             w_digit;
  logic                         w_carry;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_last   = (r_idx == IW'(DIGITS-1));

  bcd_digit_add u_dig (
    .a_d   (r_a[r_idx]),
    .b_d   (r_b[r_idx]),
    .c     (r_carry),
    .digit (w_digit),
    .carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ADD;
      ADD:     if (w_last)   w_next = DONE;
      DONE:    w_next = start ? ADD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // s is written digit by digit in place, so it only holds a full result after DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == ADD) begin
      r_s[r_idx] <= w_digit;
      r_carry    <= w_carry;
      r_idx      <= r_idx + 1'b1;
      if (w_last) r_cout <= w_carry;
    end
  end

`ifdef BCD_SERIAL_CHECK_EN
  logic r_err;
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < 2*DIGITS; i++) begin
      if (i < DIGITS) w_bad = w_bad | digit_bad(a[i*BCD_W +: BCD_W]);
      else            w_bad = w_bad | digit_bad(b[(i-DIGITS)*BCD_W +: BCD_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= w_bad;
  end

  assign err = r_err;
`endif

  assign busy = (r_state == ADD);
  assign done = (r_state == DONE);
  assign s    = r_s;
  assign cout = r_cout;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized and directed bench for bcd_serial_adder against a decimal-arithmetic model.
module tb_bcd_serial_adder;
  localparam int D = 4;
  localparam int W = 4*D;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] s;
`ifdef BCD_SERIAL_CHECK_EN
  logic         err;
`endif

  int checks   = 0;
  int failures = 0;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
`ifdef BCD_SERIAL_CHECK_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0, p = 1;
    for (int i = 0; i < D; i++) begin
      r += longint'(v[i*4 +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  function automatic longint pow10d();
    longint p = 1;
    for (int i = 0; i < D; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(9, 0));
    return r;
  endfunction

  // Plain decimal reference: (A + B + cin) split into D-digit sum and overflow carry
  task automatic ref_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         output logic [W-1:0] es, output logic ec);
    longint t = bcd2int(ta) + bcd2int(tb_) + longint'(tc);
    ec = (t >= pow10d());
    es = int2bcd(t % pow10d());
  endtask

  // Bounded wait for done; lat counts falling edges from the one where start was raised
  task automatic wait_done(inout int lat);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tc);
    int lat;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(D+1));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input logic tc);
    logic [W-1:0] es;
    logic         ec;
    ref_add(ta, tb_, tc, es, ec);
    chk({tag, "_s"}, 64'(s), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    logic [W-1:0] ra, rb, ea, eb;
    logic         rc, ec;
    int           lat, dcnt;

    rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef BCD_SERIAL_CHECK_EN
    chk("rst_err", 64'(err), 64'd0);
`endif
    rst = 1'b0;

    run_op("d1234", 16'h1234, 16'h5678, 1'b0);
    chk("d1234_s", 64'(s), 64'h6912);
    chk("d1234_cout", 64'(cout), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("hold_s", 64'(s), 64'h6912);

    run_op("d9999p1", 16'h9999, 16'h0001, 1'b0);
    chk("d9999p1_s", 64'(s), 64'h0000);
    chk("d9999p1_cout", 64'(cout), 64'd1);
    run_op("dmax", 16'h9999, 16'h9999, 1'b1);
    chk("dmax_s", 64'(s), 64'h9999);
    chk("dmax_cout", 64'(cout), 64'd1);

    // Digit > 9 through the raw formula: 1+1=2; A+0 -> 0 carry; 0+0+1=1 -> 0102
    run_op("dinv", 16'h00A1, 16'h0001, 1'b0);
    chk("dinv_s", 64'(s), 64'h0102);
    chk("dinv_cout", 64'(cout), 64'd0);
`ifdef BCD_SERIAL_CHECK_EN
    chk("err_set", 64'(err), 64'd1);
    run_op("dvalid", 16'h0010, 16'h0020, 1'b0);
    chk("err_clr", 64'(err), 64'd0);
`endif

    // Start re-asserted two cycles into ADD must be ignored
    @(negedge clk);
    a = 16'h0123; b = 16'h0456; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    @(negedge clk);
    lat++;
    a = 16'h7777; b = 16'h8888; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 64'(lat), 64'(D+1));
    check_result("ign", 16'h0123, 16'h0456, 1'b1);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("ign_once", 64'(dcnt), 64'd0);

    // Reset in the second ADD cycle aborts and clears outputs
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_s", 64'(s), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    run_op("d5p5", 16'h0005, 16'h0005, 1'b0);
    chk("d5p5_s", 64'(s), 64'h0010);
    chk("d5p5_cout", 64'(cout), 64'd0);

    // Back-to-back: start held in the DONE cycle; four ADD cycles separate the pulses
    run_op("b2b1", 16'h2500, 16'h7500, 1'b0);
    chk("b2b1_s", 64'(s), 64'h0000);
    chk("b2b1_cout", 64'(cout), 64'd1);
    a = 16'h3141; b = 16'h5926; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    chk("b2b2_busy", 64'(busy), 64'd1);
    wait_done(lat);
    chk("b2b2_lat", 64'(lat), 64'(D+1));
    check_result("b2b2", 16'h3141, 16'h5926, 1'b1);

    // Random valid-BCD operations against the decimal model
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd(); rb = rand_bcd(); rc = 1'($urandom_range(1, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_op("rnd", ra, rb, rc);
      ref_add(ra, rb, rc, ea, ec);
      chk("rnd_s", 64'(s), 64'(ea));
      chk("rnd_cout", 64'(cout), 64'(ec));
`ifdef BCD_SERIAL_CHECK_EN
      chk("rnd_err", 64'(err), 64'd0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
